// File: rtl/fix_float_pkg.sv
// Shared single-precision field widths, FSM states and class codes for the
// float <-> fixed-point converters.
package fix_float_pkg;
  localparam int unsigned SP_BIAS  = 127;
  localparam int unsigned SP_EXP_W = 8;
  localparam int unsigned SP_MAN_W = 23;
  localparam int unsigned SP_W     = 1 + SP_EXP_W + SP_MAN_W;
  // Unbiased exponent width: covers -127..128 with a sign bit to spare
  localparam int unsigned E_W      = SP_EXP_W + 2;

  typedef enum logic [1:0] {IDLE, DECODE, SHIFT, OUT} state_e;

  typedef enum logic [2:0] {ZERO, NORM, NEG, INF, NAN} sp_class_e;

  typedef struct packed {
    logic                sign;
    logic [SP_EXP_W-1:0] exp;
    logic [SP_MAN_W-1:0] man;
  } sp_word_t;
endpackage

// File: rtl/sp_unpack.sv
// Combinational split of a single-precision word into class code,
// unbiased exponent and significand with the hidden bit restored.
module sp_unpack
  import fix_float_pkg::*;
(
  input  logic [SP_W-1:0]       data_i,
  output sp_class_e             cls_c,
  output logic signed [E_W-1:0] e_c,
  output logic [SP_MAN_W:0]     sig_c
);
  sp_word_t w;
  assign w = sp_word_t'(data_i);

  // First matching rule wins: NaN, then zero/denormal, then sign, then inf
  always_comb begin
    cls_c = NORM;
    if (w.exp == '1 && w.man != '0) cls_c = NAN;
    else if (w.exp == '0)           cls_c = ZERO;
    else if (w.sign)                cls_c = NEG;
    else if (w.exp == '1)           cls_c = INF;
  end

  assign e_c   = $signed({2'b00, w.exp}) - $signed(E_W'(SP_BIAS));
  assign sig_c = {1'b1, w.man};
endmodule

// File: rtl/single_to_fix.sv
// Single-precision float to unsigned fixed-point converter with valid/ready
// handshakes on both sides; saturates and flags overflow, negative and NaN.
module single_to_fix
  import fix_float_pkg::*;
#(
  parameter int unsigned INT_WIDTH   = 8,
  parameter int unsigned FRACT_WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            valid_in,
  output logic                            ready_in,
  input  logic [31:0]                     data_in,
  output logic                            valid_out,
  input  logic                            ready_out,
  output logic [INT_WIDTH+FRACT_WIDTH-1:0] fixed_point,
  output logic                            overflow,
  output logic                            negative,
  output logic                            invalid
);
  localparam int unsigned FW    = INT_WIDTH + FRACT_WIDTH;
  localparam int unsigned SW    = SP_MAN_W + 1 + FW;
  localparam int          IW_S  = int'(INT_WIDTH);
  localparam int          FR_S  = int'(FRACT_WIDTH);
  localparam int          MAN_S = int'(SP_MAN_W);

  state_e                state_q, state_d;
  logic [SP_W-1:0]       data_q, data_d;
  sp_class_e             cls_q, cls_d, cls_c;
  logic signed [E_W-1:0] e_q, e_d, e_c;
  logic [SP_MAN_W:0]     sig_q, sig_d, sig_c;
  logic [FW-1:0]         fix_q, fix_d, res_c;
  logic                  ovf_q, ovf_d, ovf_c;
  logic                  neg_q, neg_d, neg_c;
  logic                  inv_q, inv_d, inv_c;
  logic                  ready_q, ready_d;
  logic                  valid_q, valid_d;

  sp_unpack u_unpack (
    .data_i (data_q),
    .cls_c  (cls_c),
    .e_c    (e_c),
    .sig_c  (sig_c)
  );

  // Result and flags from the decoded fields held in DECODE
  int            sh;
  logic [SW-1:0] wide;
  always_comb begin
    sh    = int'(e_q) + FR_S - MAN_S;
    wide  = SW'(sig_q);
    if (sh >= 0) wide = wide << sh;
    else         wide = wide >> (-sh);
    res_c = '0;
    ovf_c = 1'b0;
    neg_c = 1'b0;
    inv_c = 1'b0;
    case (cls_q)
      NAN: begin res_c = '1; inv_c = 1'b1; end
      NEG: neg_c = 1'b1;
      INF: begin res_c = '1; ovf_c = 1'b1; end
      NORM: begin
        // Upper-bit guard is redundant with the exponent test but cheap insurance
        if (int'(e_q) >= IW_S || |wide[SW-1:FW]) begin
          res_c = '1;
          ovf_c = 1'b1;
        end else if (int'(e_q) >= -FR_S) begin
          res_c = wide[FW-1:0];
        end
      end
      default: ;
    endcase
  end

  // Next-state and datapath register updates
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cls_d   = cls_q;
    e_d     = e_q;
    sig_d   = sig_q;
    fix_d   = fix_q;
    ovf_d   = ovf_q;
    neg_d   = neg_q;
    inv_d   = inv_q;
    case (state_q)
      IDLE: begin
        if (valid_in && ready_q) begin
          data_d  = data_in;
          state_d = DECODE;
        end
      end
      DECODE: begin
        cls_d   = cls_c;
        e_d     = e_c;
        sig_d   = sig_c;
        state_d = SHIFT;
      end
      SHIFT: begin
        fix_d   = res_c;
        ovf_d   = ovf_c;
        neg_d   = neg_c;
        inv_d   = inv_c;
        state_d = OUT;
      end
      OUT: begin
        if (ready_out) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    valid_d = (state_d == OUT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      cls_q   <= ZERO;
      e_q     <= '0;
      sig_q   <= '0;
      fix_q   <= '0;
      ovf_q   <= 1'b0;
      neg_q   <= 1'b0;
      inv_q   <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cls_q   <= cls_d;
      e_q     <= e_d;
      sig_q   <= sig_d;
      fix_q   <= fix_d;
      ovf_q   <= ovf_d;
      neg_q   <= neg_d;
      inv_q   <= inv_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end

  assign ready_in    = ready_q;
  assign valid_out   = valid_q;
  assign fixed_point = fix_q;
  assign overflow    = ovf_q;
  assign negative    = neg_q;
  assign invalid     = inv_q;
endmodule

// File: tb/tb_single_to_fix.sv
// Bench for single_to_fix (8.8 format): directed vector table, randomized
// conversions against a real-arithmetic model, backpressure and mid-op reset.
module tb_single_to_fix;
  localparam int unsigned IW  = 8;
  localparam int unsigned FRW = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_in = 1'b0;
  logic        ready_in;
  logic [31:0] data_in = '0;
  logic        valid_out;
  logic        ready_out = 1'b1;
  logic [15:0] fixed_point;
  logic        overflow, negative, invalid;

  always #5 clk = ~clk;

  single_to_fix #(.INT_WIDTH(IW), .FRACT_WIDTH(FRW)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (valid_in),
    .ready_in   (ready_in),
    .data_in    (data_in),
    .valid_out  (valid_out),
    .ready_out  (ready_out),
    .fixed_point(fixed_point),
    .overflow   (overflow),
    .negative   (negative),
    .invalid    (invalid)
  );

  typedef struct {
    logic [31:0] d;
    logic [18:0] exp;  // {fixed_point, overflow, negative, invalid}
  } vec_t;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference: evaluate the float's real value and scale by 2^FRACT_WIDTH
  function automatic logic [18:0] model(input logic [31:0] d);
    int  ex;
    int  m;
    real v;
    ex = int'(d[30:23]);
    m  = int'(d[22:0]);
    if (ex == 255 && m != 0) return {16'hFFFF, 3'b001};
    if (ex == 0)             return 19'd0;
    if (d[31])               return {16'h0000, 3'b010};
    if (ex == 255)           return {16'hFFFF, 3'b100};
    v = 1.0 + real'(m) / 8388608.0;
    for (int k = 0; k < ex - 127; k++) v = v * 2.0;
    for (int k = 0; k < 127 - ex; k++) v = v / 2.0;
    if (v >= 256.0) return {16'hFFFF, 3'b100};
    return {16'($rtoi(v * 256.0)), 3'b000};
  endfunction

  // Wait (bounded) for ready_in, then present one input for one accept edge
  task automatic send(input logic [31:0] d);
    int guard = 0;
    @(negedge clk);
    while (!ready_in && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("ready_in_before_send", 32'(ready_in), 32'd1);
    valid_in = 1'b1;
    data_in  = d;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    data_in  = $urandom;
  endtask

  // Count edges from the accept edge (counted as 1) until valid_out is seen
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!valid_out && lat < 12) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic xfer(input logic [31:0] d, output logic [18:0] res, output int lat);
    send(d);
    wait_valid(lat);
    res = {fixed_point, overflow, negative, invalid};
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t        tbl[14];
    logic [18:0] res;
    int          lat;
    logic [31:0] d;
    logic [31:0] specials[6];

    tbl[0]  = '{32'h3F800000, {16'h0100, 3'b000}};
    tbl[1]  = '{32'h40200000, {16'h0280, 3'b000}};
    tbl[2]  = '{32'h40700000, {16'h03C0, 3'b000}};
    tbl[3]  = '{32'h40A40000, {16'h0520, 3'b000}};
    tbl[4]  = '{32'h437FFF00, {16'hFFFF, 3'b000}};
    tbl[5]  = '{32'h43800000, {16'hFFFF, 3'b100}};
    tbl[6]  = '{32'h7F800000, {16'hFFFF, 3'b100}};
    tbl[7]  = '{32'h3B800000, {16'h0001, 3'b000}};
    tbl[8]  = '{32'h3B000000, {16'h0000, 3'b000}};
    tbl[9]  = '{32'h00000000, {16'h0000, 3'b000}};
    tbl[10] = '{32'h80000000, {16'h0000, 3'b000}};
    tbl[11] = '{32'hBF800000, {16'h0000, 3'b010}};
    tbl[12] = '{32'h7FC00000, {16'hFFFF, 3'b001}};
    tbl[13] = '{32'hFF800000, {16'h0000, 3'b010}};

    specials[0] = 32'h7F800000;
    specials[1] = 32'hFF800000;
    specials[2] = 32'h7FC00001;
    specials[3] = 32'h00000001;
    specials[4] = 32'h80400000;
    specials[5] = 32'h437FFFFF;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready_in", 32'(ready_in), 32'd1);
    chk("reset_valid_out", 32'(valid_out), 32'd0);
    chk("reset_fixed_point", 32'(fixed_point), 32'd0);
    chk("reset_flags", 32'({overflow, negative, invalid}), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Directed vector table
    for (int i = 0; i < 14; i++) begin
      xfer(tbl[i].d, res, lat);
      chk($sformatf("vec%0d_%h_result", i, tbl[i].d), 32'(res), 32'(tbl[i].exp));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
    end

    // Randomized conversions against the real-valued model
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        d = specials[$urandom_range(0, 5)];
      end else begin
        d[31]    = ($urandom_range(0, 7) == 0);
        d[30:23] = 8'($urandom_range(108, 138));
        d[22:0]  = 23'($urandom);
      end
      xfer(d, res, lat);
      chk($sformatf("rand%0d_%h", i, d), 32'(res), 32'(model(d)));
    end

    // Backpressure: result holds while ready_out is low, input changes ignored
    send(32'h40200000);
    ready_out = 1'b0;
    wait_valid(lat);
    chk("bp_latency", 32'(lat), 32'd3);
    for (int i = 0; i < 6; i++) begin
      data_in  = $urandom;
      valid_in = (i % 2 == 0);
      chk($sformatf("bp%0d_fixed_point", i), 32'(fixed_point), 32'h0280);
      chk($sformatf("bp%0d_valid_out", i), 32'(valid_out), 32'd1);
      chk($sformatf("bp%0d_ready_in", i), 32'(ready_in), 32'd0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    valid_in  = 1'b0;
    ready_out = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_ready_after_handshake", 32'(ready_in), 32'd1);
    chk("bp_valid_after_handshake", 32'(valid_out), 32'd0);

    // Reset while in SHIFT drops the pending result
    send(32'h40700000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_mid_ready_in", 32'(ready_in), 32'd1);
    chk("rst_mid_valid_out", 32'(valid_out), 32'd0);
    chk("rst_mid_fixed_point", 32'(fixed_point), 32'd0);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("rst_hold_valid_out", 32'(valid_out), 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("rst_no_stale_valid", 32'(valid_out), 32'd0);
    end
    xfer(32'h3F800000, res, lat);
    chk("rst_after_result", 32'(res), 32'({16'h0100, 3'b000}));
    chk("rst_after_latency", 32'(lat), 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
